fetch_unit: RTL and testbench

- Instruction-fetch stage of the 16-bit single-cycle CPU, directly upstream of the control unit.
- Owns the PC and fetches one 16-bit word per instruction from a variable-latency instruction memory using a req/ack handshake.
- Holds the word in an instruction register and splits out opcode/funct/register/immediate fields for the control unit and datapath.
- Computes the next PC from the branch/jump controls and ALU zero flag of the instruction being executed.

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/next_pc_logic.sv | 48 ++++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared opcodes, instruction field positions and fetch states.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_LW    = 4'h1;
    localparam logic [3:0] OP_SW    = 4'h2;
    localparam logic [3:0] OP_ADDI  = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_BNE   = 4'h5;
    localparam logic [3:0] OP_J     = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam int OPCODE_MSB  = 15;
    localparam int OPCODE_LSB  = 12;
    localparam int RS_MSB      = 11;
    localparam int RS_LSB      = 8;
    localparam int RT_MSB      = 7;
    localparam int RT_LSB      = 4;
    localparam int FUNCT_MSB   = 3;
    localparam int FUNCT_LSB   = 0;
    localparam int JTARGET_MSB = 11;
    localparam int JTARGET_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/next_pc_logic.sv
// ============================================================================
// Module : next_pc_logic
// Brief  : Combinational next-PC select: jump > taken branch > sequential.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module next_pc_logic
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [3:0]        funct,
    input  logic [11:0]       jtarget,
    input  logic [3:0]        opcode,
    input  logic              branch,
    input  logic              jump,
    input  logic              alu_zero,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] offset;
    logic              taken;

    assign seq_pc = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign offset = {{(ADDR_W-4){funct[3]}}, funct};

    always_comb begin
        taken = 1'b0;
        if (branch) begin
            if (opcode == OP_BEQ) taken = alu_zero;
            else if (opcode == OP_BNE) taken = ~alu_zero;
        end
    end

    always_comb begin
        next_pc = seq_pc;
        if (jump)
            next_pc = {pc[ADDR_W-1:12], jtarget};
        else if (taken)
            next_pc = seq_pc + offset;
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module : fetch_unit
// Brief  : PC owner and req/ack instruction fetch with field decode.
//          Optional halt support with macro FETCH_HALT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              instr_valid,
    output logic [15:0]       instr,
    output logic [3:0]        opcode,
    output logic [3:0]        rs,
    output logic [3:0]        rt,
    output logic [3:0]        funct,
    output logic [11:0]       jtarget,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus1,
`ifdef FETCH_HALT_EN
    output logic              halted,
`endif
    input  logic              exec_done,
    input  logic              branch,
    input  logic              jump,
    input  logic              alu_zero
);

    fetch_state_t      state, next_state;
    logic              load_instr;
    logic              update_pc;
    logic [ADDR_W-1:0] next_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        load_instr = 1'b0;
        update_pc  = 1'b0;
        case (state)
            ST_IDLE: next_state = ST_REQ;
            ST_REQ: begin
                if (imem_ack) begin
                    load_instr = 1'b1;
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (exec_done) begin
`ifdef FETCH_HALT_EN
                    if (opcode == OP_HALT) begin
                        next_state = ST_HALT;
                    end else begin
                        update_pc  = 1'b1;
                        next_state = ST_REQ;
                    end
`else
                    update_pc  = 1'b1;
                    next_state = ST_REQ;
`endif
                end
            end
`ifdef FETCH_HALT_EN
            ST_HALT: next_state = ST_HALT;
`endif
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            instr <= 16'h0000;
        end else begin
            if (load_instr) instr <= imem_rdata;
            if (update_pc)  pc    <= next_pc;
        end
    end

    next_pc_logic #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc       (pc),
        .funct    (funct),
        .jtarget  (jtarget),
        .opcode   (opcode),
        .branch   (branch),
        .jump     (jump),
        .alu_zero (alu_zero),
        .next_pc  (next_pc)
    );

    // Handshake outputs decode straight from state so reset clears them asynchronously.
    assign imem_req    = (state == ST_REQ);
    assign instr_valid = (state == ST_ISSUE);
`ifdef FETCH_HALT_EN
    assign halted      = (state == ST_HALT);
`endif

    assign imem_addr = pc;
    assign pc_plus1  = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign opcode    = instr[OPCODE_MSB:OPCODE_LSB];
    assign rs        = instr[RS_MSB:RS_LSB];
    assign rt        = instr[RT_MSB:RT_LSB];
    assign funct     = instr[FUNCT_MSB:FUNCT_LSB];
    assign jtarget   = instr[JTARGET_MSB:JTARGET_LSB];

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module : tb_fetch_unit
// Brief  : Randomized and directed bench for fetch_unit against a PC model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [3:0]  opcode, rs, rt, funct;
    logic [11:0] jtarget;
    logic [15:0] pc, pc_plus1;
    logic        exec_done, branch, jump, alu_zero;
`ifdef FETCH_HALT_EN
    logic        halted;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] model_pc;

    fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .funct       (funct),
        .jtarget     (jtarget),
        .pc          (pc),
        .pc_plus1    (pc_plus1),
`ifdef FETCH_HALT_EN
        .halted      (halted),
`endif
        .exec_done   (exec_done),
        .branch      (branch),
        .jump        (jump),
        .alu_zero    (alu_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference next PC from the architectural rules, using plain integer arithmetic.
    function automatic logic [15:0] ref_next_pc(input logic [15:0] p, input logic [15:0] w,
                                                input bit br, input bit jmp, input bit z);
        int off, nxt;
        off = int'(w[3:0]);
        if (off >= 8) off = off - 16;
        if (jmp)
            nxt = (int'(p) & 32'hF000) + int'(w[11:0]);
        else if (br && ((w[15:12] == 4'h4 && z) || (w[15:12] == 4'h5 && !z)))
            nxt = (int'(p) + 1 + off) & 32'hFFFF;
        else
            nxt = (int'(p) + 1) & 32'hFFFF;
        return nxt[15:0];
    endfunction

    // One full instruction: wait for req, ack after lat cycles, dwell in issue, execute.
    task automatic run_instr(input logic [15:0] w, input int lat, input bit br, input bit jmp,
                             input bit z, input int dwell, input bit spur);
        int n;
        logic [15:0] exp_pc;
        bit will_halt;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            check("req_timeout", 32'(imem_req), 32'd1);
            return;
        end
        check("imem_addr", 32'(imem_addr), 32'(model_pc));
        for (int i = 0; i < lat; i++) begin
            if (i == 0 && spur) begin
                exec_done = 1'b1; jump = 1'b1; branch = 1'b1;
            end
            @(negedge clk);
            exec_done = 1'b0; jump = 1'b0; branch = 1'b0;
            check("req_hold", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, model_pc});
        end
        imem_ack = 1'b1;
        imem_rdata = w;
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = 16'($urandom);
        check("valid_rise", {15'd0, instr_valid, instr}, {15'd0, 1'b1, w});
        check("fields", {4'd0, opcode, rs, rt, funct, jtarget},
              {4'd0, w[15:12], w[11:8], w[7:4], w[3:0], w[11:0]});
        check("pc_pair", {pc, pc_plus1}, {model_pc, model_pc + 16'd1});
        for (int i = 0; i < dwell; i++) begin
            imem_ack = 1'($urandom);
            @(negedge clk);
            imem_ack = 1'b0;
            check("issue_hold", {15'd0, instr_valid, instr}, {15'd0, 1'b1, w});
        end
        exec_done = 1'b1; branch = br; jump = jmp; alu_zero = z;
        exp_pc = ref_next_pc(model_pc, w, br, jmp, z);
        will_halt = 1'b0;
`ifdef FETCH_HALT_EN
        if (w[15:12] == 4'hF) begin
            will_halt = 1'b1;
            exp_pc = model_pc;
        end
`endif
        @(negedge clk);
        exec_done = 1'b0; branch = 1'b0; jump = 1'b0;
        check("valid_fall", 32'(instr_valid), 32'd0);
        check("next_pc", 32'(pc), 32'(exp_pc));
        model_pc = exp_pc;
        if (will_halt) begin
`ifdef FETCH_HALT_EN
            check("halted", 32'(halted), 32'd1);
`endif
        end else begin
            check("req_after_exec", 32'(imem_req), 32'd1);
        end
    endtask

    initial begin
        logic [15:0] w;
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0000;
        exec_done = 1'b0; branch = 1'b0; jump = 1'b0; alu_zero = 1'b0;
        model_pc = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_state", {imem_req, instr_valid, 14'd0, pc}, 32'h0000_0000);
        check("rst_instr", 32'(instr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_instr(16'h0123, 2, 0, 0, 0, 0, 0);
        run_instr(16'h6005, 0, 0, 1, 0, 0, 0);
        run_instr(16'h0000, 1, 0, 0, 0, 1, 1);
        check("seq_0006", 32'(imem_addr), 32'h0006);
        run_instr(16'h6010, 0, 0, 1, 0, 0, 0);
        run_instr(16'h412E, 0, 1, 0, 1, 0, 0);
        check("beq_taken", 32'(pc), 32'h000F);
        run_instr(16'h6010, 0, 0, 1, 0, 0, 0);
        run_instr(16'h412E, 0, 1, 0, 0, 0, 0);
        check("beq_not", 32'(pc), 32'h0011);
        run_instr(16'h6020, 0, 0, 1, 0, 0, 0);
        run_instr(16'h5003, 0, 1, 0, 0, 0, 0);
        check("bne_taken", 32'(pc), 32'h0024);
        run_instr(16'h6FFF, 0, 0, 1, 0, 0, 0);
        run_instr(16'h0000, 0, 0, 0, 0, 0, 0);
        run_instr(16'h6234, 0, 0, 1, 0, 0, 0);
        run_instr(16'h6ABC, 0, 1, 1, 1, 0, 0);
        check("jump_wins", 32'(pc), 32'h1ABC);

        // Climb through each 4K page to reach the top of the address space
        while (model_pc[15:12] != 4'hF) begin
            run_instr(16'h6FFF, 0, 0, 1, 0, 0, 0);
            run_instr(16'h0000, 0, 0, 0, 0, 0, 0);
        end
        run_instr(16'h6FFF, 0, 0, 1, 0, 0, 0);
        check("at_ffff", 32'(pc), 32'hFFFF);
        run_instr(16'h0000, 1, 0, 0, 0, 2, 1);
        check("wrap_0000", 32'(imem_addr), 32'h0000);

        // Randomized instruction stream
        for (int k = 0; k < 150; k++) begin
            w = 16'($urandom);
`ifdef FETCH_HALT_EN
            if (w[15:12] == 4'hF) w[15:12] = 4'hE;
`endif
            if ($urandom_range(0, 2) == 0) w[15:12] = 4'h4 + 4'($urandom_range(0, 1));
            run_instr(w, $urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 4) == 0),
                      1'($urandom), $urandom_range(0, 2), 1'($urandom));
        end

        // Reset in the middle of a request, with an ack landing just after release
        run_instr(16'h0001, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1 check("rst_midreq", {imem_req, instr_valid, 14'd0, pc}, 32'h0000_0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 16'hBEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        check("late_ack_ignored", {15'd0, instr_valid, imem_req, 15'd0}, 32'h0000_8000);
        model_pc = 16'h0000;
        run_instr(16'h0777, 1, 0, 0, 0, 0, 0);

`ifdef FETCH_HALT_EN
        run_instr(16'hF000, 0, 0, 0, 0, 0, 0);
        repeat (4) begin
            @(negedge clk);
            check("halt_no_req", {imem_req, instr_valid, halted, 13'd0, pc},
                  {3'b001, 13'd0, model_pc});
        end
`else
        run_instr(16'hF000, 0, 0, 0, 0, 0, 0);
        check("opf_seq", 32'(imem_addr), 32'h0002);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
